chimp_sequence_fsm: RTL and testbench

Parametrised control FSM for the chimp memory test. It sequences start, board load, ordered number selection, level advance, strikes and game end. Level, target and strike state live in registers, so one counter-based FSM covers any maximum level instead of one enumerated state per number. It sits between the keyboard/tile-select logic and the board datapath, in place of the per-level enumerated control path. It adds a strike (lives) budget, a hide-after-first-pick mode, a win state and a score output.

---
 rtl/chimp_sequence_fsm_if.sv | 32 +++
 rtl/chimp_sequence_fsm.sv | 131 +++++++++++++
 tb/tb_chimp_sequence_fsm.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chimp_sequence_fsm_if.sv
// Handshake bundle between the chimp control FSM and its keyboard/datapath neighbours.
// The master side drives the key and pick inputs; the slave side is the FSM.
interface chimp_sequence_fsm_if #(
  parameter int NUM_W = 5,
  parameter int STR_W = 2
);
  logic             iSpace;
  logic             iDoneLoad;
  logic             iChoseCorrectNum;
  logic             iChoseWrongNum;
  logic [NUM_W-1:0] oLevel;
  logic [NUM_W-1:0] oNumToChoose;
  logic             oLoadEnable;
  logic             oShowEnable;
  logic             oResetBoard;
  logic [STR_W-1:0] oStrikes;
  logic [NUM_W-1:0] oScore;
  logic             oGameOver;
  logic             oWin;

  modport master (
    output iSpace, iDoneLoad, iChoseCorrectNum, iChoseWrongNum,
    input  oLevel, oNumToChoose, oLoadEnable, oShowEnable, oResetBoard,
    input  oStrikes, oScore, oGameOver, oWin
  );

  modport slave (
    input  iSpace, iDoneLoad, iChoseCorrectNum, iChoseWrongNum,
    output oLevel, oNumToChoose, oLoadEnable, oShowEnable, oResetBoard,
    output oStrikes, oScore, oGameOver, oWin
  );
endinterface

// File: rtl/chimp_sequence_fsm.sv
// Counter-based control FSM for the chimp memory test: start, load, ordered picks,
// level advance, strikes and game end. All outputs are decoded from registers only.
module chimp_sequence_fsm #(
  parameter int MAX_LEVEL        = 31,
  parameter int START_LEVEL      = 4,
  parameter int NUM_W            = 5,
  parameter int STRIKES          = 3,
  parameter int HIDE_AFTER_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 iReset,
  chimp_sequence_fsm_if.slave  bus
);
  localparam int STR_W = $clog2(STRIKES + 1);
  localparam logic [NUM_W-1:0] MAX_LVL   = NUM_W'(MAX_LEVEL);
  localparam logic [NUM_W-1:0] START_LVL = NUM_W'(START_LEVEL);
  localparam logic [STR_W-1:0] STR_MAX   = STR_W'(STRIKES);
  localparam logic [STR_W-1:0] STR_LAST  = STR_W'(STRIKES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LOAD, S_CHOOSE, S_LEVEL_DONE, S_STRIKE, S_END
  } state_e;

  state_e           state_q, state_d;
  logic [NUM_W-1:0] level_q, level_d;
  logic [NUM_W-1:0] target_q, target_d;
  logic [STR_W-1:0] strikes_q, strikes_d;
  logic [NUM_W-1:0] score_q, score_d;
  logic             win_q, win_d;

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      level_q   <= START_LVL;
      target_q  <= '0;
      strikes_q <= '0;
      score_q   <= '0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      target_q  <= target_d;
      strikes_q <= strikes_d;
      score_q   <= score_d;
      win_q     <= win_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    level_d          = level_q;
    target_d         = target_q;
    strikes_d        = strikes_q;
    score_d          = score_q;
    win_d            = win_q;
    bus.oLoadEnable  = 1'b0;
    bus.oShowEnable  = 1'b0;
    bus.oResetBoard  = 1'b0;
    bus.oGameOver    = 1'b0;
    bus.oWin         = 1'b0;
    bus.oNumToChoose = '0;

    case (state_q)
      S_IDLE: begin
        bus.oResetBoard = 1'b1;
        if (bus.iSpace) begin
          // Game progress is cleared on every entry into ARM.
          state_d   = S_ARM;
          level_d   = START_LVL;
          target_d  = '0;
          strikes_d = '0;
          score_d   = '0;
        end
      end
      S_ARM: begin
        bus.oResetBoard = 1'b1;
        if (!bus.iSpace) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.oLoadEnable = 1'b1;
        bus.oShowEnable = 1'b1;
        if (bus.iDoneLoad) begin
          state_d  = S_CHOOSE;
          target_d = NUM_W'(1);
        end
      end
      S_CHOOSE: begin
        bus.oNumToChoose = target_q;
        bus.oShowEnable  = (HIDE_AFTER_FIRST == 0) || (target_q == NUM_W'(1));
        // A wrong pulse wins over a simultaneous correct pulse.
        if (bus.iChoseWrongNum) begin
          state_d = S_STRIKE;
        end else if (bus.iChoseCorrectNum) begin
          if (target_q == level_q) state_d = S_LEVEL_DONE;
          else                     target_d = target_q + NUM_W'(1);
        end
      end
      S_LEVEL_DONE: begin
        score_d = level_q;
        if (level_q == MAX_LVL) begin
          win_d   = 1'b1;
          state_d = S_END;
        end else begin
          level_d = level_q + NUM_W'(1);
          state_d = S_LOAD;
        end
      end
      S_STRIKE: begin
        if (strikes_q != STR_MAX) strikes_d = strikes_q + STR_W'(1);
        state_d = (strikes_q == STR_LAST) ? S_END : S_LOAD;
      end
      S_END: begin
        bus.oGameOver = 1'b1;
        bus.oWin      = win_q;
        if (bus.iSpace) begin
          state_d   = S_ARM;
          win_d     = 1'b0;
          level_d   = START_LVL;
          target_d  = '0;
          strikes_d = '0;
          score_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.oLevel   = level_q;
  assign bus.oStrikes = strikes_q;
  assign bus.oScore   = score_q;
endmodule

// File: tb/tb_chimp_sequence_fsm.sv
// Bench for chimp_sequence_fsm: directed scenarios plus randomized games checked
// against a game-rule model (level, next number, strikes, score).
module tb_chimp_sequence_fsm;
  logic clk = 1'b0;
  logic iReset = 1'b1;
  always #5 clk = ~clk;

  chimp_sequence_fsm_if #(.NUM_W(5), .STR_W(2)) m_if ();
  chimp_sequence_fsm_if #(.NUM_W(3), .STR_W(2)) w_if ();

  chimp_sequence_fsm #(.MAX_LEVEL(31), .START_LEVEL(4), .NUM_W(5), .STRIKES(3),
                       .HIDE_AFTER_FIRST(1)) dut (.clk(clk), .iReset(iReset), .bus(m_if));
  chimp_sequence_fsm #(.MAX_LEVEL(5), .START_LEVEL(5), .NUM_W(3), .STRIKES(3),
                       .HIDE_AFTER_FIRST(1)) dut_win (.clk(clk), .iReset(iReset), .bus(w_if));

  int n_checks = 0;
  int n_fail = 0;

  // {oResetBoard, oLoadEnable, oShowEnable, oGameOver, oWin}
  function automatic logic [4:0] mflags();
    return {m_if.oResetBoard, m_if.oLoadEnable, m_if.oShowEnable, m_if.oGameOver, m_if.oWin};
  endfunction
  function automatic logic [4:0] wflags();
    return {w_if.oResetBoard, w_if.oLoadEnable, w_if.oShowEnable, w_if.oGameOver, w_if.oWin};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    tick();
    tick();
    iReset = 1'b0;
    n_checks++; if (mflags() !== 5'b10000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", mflags(), 5'b10000); end
    n_checks++; if (m_if.oNumToChoose !== 5'd0) begin n_fail++; $display("FAIL reset_num: got %0d expected 0", m_if.oNumToChoose); end
    n_checks++; if (m_if.oLevel !== 5'd4) begin n_fail++; $display("FAIL reset_level: got %0d expected 4", m_if.oLevel); end
    n_checks++; if ({m_if.oStrikes, m_if.oScore} !== 7'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", m_if.oStrikes, m_if.oScore); end
    n_checks++; if (w_if.oLevel !== 3'd5 || wflags() !== 5'b10000) begin n_fail++; $display("FAIL reset_win_dut: got level %0d flags %b expected 5 10000", w_if.oLevel, wflags()); end
    tick();
    n_checks++; if (mflags() !== 5'b10000) begin n_fail++; $display("FAIL idle_hold: got %b expected %b", mflags(), 5'b10000); end
    $display("reset: checked idle outputs");
  endtask

  // Press, hold, release space, then finish the load; leaves the DUT in CHOOSE at target 1.
  task automatic start_main();
    m_if.iSpace = 1'b1;
    tick();
    n_checks++; if (mflags() !== 5'b10000) begin n_fail++; $display("FAIL arm_entry: got %b expected %b", mflags(), 5'b10000); end
    tick();
    n_checks++; if (mflags() !== 5'b10000) begin n_fail++; $display("FAIL arm_hold: got %b expected %b", mflags(), 5'b10000); end
    m_if.iSpace = 1'b0;
    tick();
    n_checks++; if (mflags() !== 5'b01100 || m_if.oLevel !== 5'd4) begin n_fail++; $display("FAIL load_entry: got flags %b level %0d expected 01100 4", mflags(), m_if.oLevel); end
    m_if.iDoneLoad = 1'b1;
    tick();
    m_if.iDoneLoad = 1'b0;
    n_checks++; if (m_if.oNumToChoose !== 5'd1 || mflags() !== 5'b00100) begin n_fail++; $display("FAIL choose_entry: got num %0d flags %b expected 1 00100", m_if.oNumToChoose, mflags()); end
    $display("start: game started at level %0d", m_if.oLevel);
  endtask

  task automatic clear_level(input int lvl);
    for (int n = 1; n <= lvl; n++) begin
      n_checks++; if (m_if.oNumToChoose !== 5'(n)) begin n_fail++; $display("FAIL pick_target: got %0d expected %0d", m_if.oNumToChoose, n); end
      m_if.iChoseCorrectNum = 1'b1;
      tick();
      m_if.iChoseCorrectNum = 1'b0;
      if (n == 1) begin
        n_checks++; if (m_if.oShowEnable !== 1'b0) begin n_fail++; $display("FAIL hide_after_first: got %b expected 0", m_if.oShowEnable); end
      end
    end
    n_checks++; if (mflags() !== 5'b00000 || m_if.oNumToChoose !== 5'd0) begin n_fail++; $display("FAIL level_done: got flags %b num %0d expected 00000 0", mflags(), m_if.oNumToChoose); end
    tick();
    n_checks++; if (mflags() !== 5'b01100 || m_if.oLevel !== 5'(lvl + 1) || m_if.oScore !== 5'(lvl)) begin n_fail++; $display("FAIL level_advance: got flags %b level %0d score %0d expected 01100 %0d %0d", mflags(), m_if.oLevel, m_if.oScore, lvl + 1, lvl); end
    $display("level: cleared level %0d", lvl);
  endtask

  task automatic test_level_clear();
    start_main();
    clear_level(4);
  endtask

  task automatic test_strikes();
    for (int k = 1; k <= 3; k++) begin
      m_if.iDoneLoad = 1'b1;
      tick();
      m_if.iDoneLoad = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_if.iChoseCorrectNum = 1'b1;
        tick();
        m_if.iChoseCorrectNum = 1'b0;
      end
      n_checks++; if (m_if.oNumToChoose !== 5'd3) begin n_fail++; $display("FAIL strike_target: got %0d expected 3", m_if.oNumToChoose); end
      m_if.iChoseWrongNum = 1'b1;
      tick();
      m_if.iChoseWrongNum = 1'b0;
      n_checks++; if (mflags() !== 5'b00000 || m_if.oStrikes !== 2'(k - 1)) begin n_fail++; $display("FAIL strike_state: got flags %b strikes %0d expected 00000 %0d", mflags(), m_if.oStrikes, k - 1); end
      tick();
      if (k < 3) begin
        n_checks++; if (mflags() !== 5'b01100 || m_if.oStrikes !== 2'(k) || m_if.oLevel !== 5'd5) begin n_fail++; $display("FAIL strike_reload: got flags %b strikes %0d level %0d expected 01100 %0d 5", mflags(), m_if.oStrikes, m_if.oLevel, k); end
      end else begin
        n_checks++; if (mflags() !== 5'b00010 || m_if.oStrikes !== 2'd3 || m_if.oLevel !== 5'd5 || m_if.oScore !== 5'd4) begin n_fail++; $display("FAIL game_lost: got flags %b strikes %0d level %0d score %0d expected 00010 3 5 4", mflags(), m_if.oStrikes, m_if.oLevel, m_if.oScore); end
      end
      $display("strike: wrong pick %0d at level 5", k);
    end
  endtask

  task automatic test_end_ignores_and_restart();
    m_if.iChoseCorrectNum = 1'b1;
    m_if.iDoneLoad = 1'b1;
    tick();
    m_if.iChoseCorrectNum = 1'b0;
    m_if.iDoneLoad = 1'b0;
    n_checks++; if (mflags() !== 5'b00010 || m_if.oStrikes !== 2'd3) begin n_fail++; $display("FAIL end_ignores: got flags %b strikes %0d expected 00010 3", mflags(), m_if.oStrikes); end
    start_main();
    n_checks++; if (m_if.oStrikes !== 2'd0 || m_if.oScore !== 5'd0) begin n_fail++; $display("FAIL restart_counters: got %0d/%0d expected 0/0", m_if.oStrikes, m_if.oScore); end
  endtask

  task automatic test_both_pulses();
    m_if.iChoseCorrectNum = 1'b1;
    tick();
    m_if.iChoseCorrectNum = 1'b0;
    m_if.iChoseCorrectNum = 1'b1;
    m_if.iChoseWrongNum = 1'b1;
    tick();
    m_if.iChoseCorrectNum = 1'b0;
    m_if.iChoseWrongNum = 1'b0;
    n_checks++; if (mflags() !== 5'b00000 || m_if.oNumToChoose !== 5'd0) begin n_fail++; $display("FAIL both_strike_state: got flags %b num %0d expected 00000 0", mflags(), m_if.oNumToChoose); end
    tick();
    n_checks++; if (m_if.oStrikes !== 2'd1 || m_if.oLevel !== 5'd4 || mflags() !== 5'b01100) begin n_fail++; $display("FAIL both_strike_count: got strikes %0d level %0d flags %b expected 1 4 01100", m_if.oStrikes, m_if.oLevel, mflags()); end
    m_if.iDoneLoad = 1'b1;
    tick();
    m_if.iDoneLoad = 1'b0;
    n_checks++; if (m_if.oNumToChoose !== 5'd1) begin n_fail++; $display("FAIL both_reload_target: got %0d expected 1", m_if.oNumToChoose); end
    $display("both: simultaneous pulses counted as a strike");
  endtask

  task automatic test_reset_mid();
    clear_level(4);
    m_if.iDoneLoad = 1'b1;
    tick();
    m_if.iDoneLoad = 1'b0;
    m_if.iChoseCorrectNum = 1'b1;
    tick();
    m_if.iChoseCorrectNum = 1'b0;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    n_checks++; if (mflags() !== 5'b10000 || m_if.oNumToChoose !== 5'd0) begin n_fail++; $display("FAIL midreset_flags: got flags %b num %0d expected 10000 0", mflags(), m_if.oNumToChoose); end
    n_checks++; if (m_if.oLevel !== 5'd4 || m_if.oStrikes !== 2'd0 || m_if.oScore !== 5'd0) begin n_fail++; $display("FAIL midreset_counters: got level %0d strikes %0d score %0d expected 4 0 0", m_if.oLevel, m_if.oStrikes, m_if.oScore); end
    m_if.iChoseWrongNum = 1'b1;
    tick();
    m_if.iChoseWrongNum = 1'b0;
    n_checks++; if (mflags() !== 5'b10000 || m_if.oStrikes !== 2'd0) begin n_fail++; $display("FAIL idle_ignores_pick: got flags %b strikes %0d expected 10000 0", mflags(), m_if.oStrikes); end
    $display("midreset: progress discarded");
  endtask

  task automatic test_win();
    w_if.iSpace = 1'b1;
    tick();
    w_if.iSpace = 1'b0;
    tick();
    w_if.iDoneLoad = 1'b1;
    tick();
    w_if.iDoneLoad = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      w_if.iChoseCorrectNum = 1'b1;
      tick();
      w_if.iChoseCorrectNum = 1'b0;
    end
    tick();
    n_checks++; if (wflags() !== 5'b00011 || w_if.oScore !== 3'd5 || w_if.oLevel !== 3'd5) begin n_fail++; $display("FAIL win_end: got flags %b score %0d level %0d expected 00011 5 5", wflags(), w_if.oScore, w_if.oLevel); end
    w_if.iSpace = 1'b1;
    tick();
    n_checks++; if (wflags() !== 5'b10000 || w_if.oScore !== 3'd0 || w_if.oStrikes !== 2'd0) begin n_fail++; $display("FAIL win_rearm: got flags %b score %0d strikes %0d expected 10000 0 0", wflags(), w_if.oScore, w_if.oStrikes); end
    w_if.iSpace = 1'b0;
    tick();
    n_checks++; if (wflags() !== 5'b01100 || w_if.oLevel !== 3'd5 || w_if.oScore !== 3'd0) begin n_fail++; $display("FAIL win_newgame: got flags %b level %0d score %0d expected 01100 5 0", wflags(), w_if.oLevel, w_if.oScore); end
    $display("win: cleared max level and restarted");
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 6; g++) begin
      int lvl, tgt, str, sc, r;
      bit over, won, next_load;
      m_if.iSpace = 1'b1;
      tick();
      m_if.iSpace = 1'b0;
      tick();
      lvl = 4; str = 0; sc = 0; over = 0; won = 0;
      while (!over) begin
        n_checks++; if (m_if.oLoadEnable !== 1'b1 || m_if.oLevel !== 5'(lvl) || m_if.oStrikes !== 2'(str) || m_if.oScore !== 5'(sc)) begin n_fail++; $display("FAIL rnd_load: got le %b level %0d strikes %0d score %0d expected 1 %0d %0d %0d", m_if.oLoadEnable, m_if.oLevel, m_if.oStrikes, m_if.oScore, lvl, str, sc); end
        for (int w = $urandom_range(0, 2); w > 0; w--) begin
          m_if.iChoseWrongNum = 1'($urandom_range(0, 1));
          m_if.iChoseCorrectNum = 1'($urandom_range(0, 1));
          tick();
          m_if.iChoseWrongNum = 1'b0;
          m_if.iChoseCorrectNum = 1'b0;
        end
        m_if.iDoneLoad = 1'b1;
        tick();
        m_if.iDoneLoad = 1'b0;
        tgt = 1;
        next_load = 0;
        while (!next_load) begin
          n_checks++; if (m_if.oNumToChoose !== 5'(tgt) || m_if.oShowEnable !== (tgt == 1)) begin n_fail++; $display("FAIL rnd_choose: got num %0d show %b expected %0d %b", m_if.oNumToChoose, m_if.oShowEnable, tgt, tgt == 1); end
          r = int'($urandom_range(0, 99));
          if (r < 8) begin
            tick();
          end else if (r < 16) begin
            m_if.iChoseWrongNum = 1'b1;
            m_if.iChoseCorrectNum = (r >= 13);
            tick();
            m_if.iChoseWrongNum = 1'b0;
            m_if.iChoseCorrectNum = 1'b0;
            tick();
            str++;
            over = (str == 3);
            next_load = 1;
          end else begin
            m_if.iChoseCorrectNum = 1'b1;
            tick();
            m_if.iChoseCorrectNum = 1'b0;
            if (tgt == lvl) begin
              tick();
              sc = lvl;
              if (lvl == 31) begin won = 1; over = 1; end
              else lvl++;
              next_load = 1;
            end else begin
              tgt++;
            end
          end
        end
      end
      n_checks++; if (m_if.oGameOver !== 1'b1 || m_if.oWin !== won || m_if.oLevel !== 5'(lvl) || m_if.oStrikes !== 2'(str) || m_if.oScore !== 5'(sc)) begin n_fail++; $display("FAIL rnd_end: got go %b win %b level %0d strikes %0d score %0d expected 1 %b %0d %0d %0d", m_if.oGameOver, m_if.oWin, m_if.oLevel, m_if.oStrikes, m_if.oScore, won, lvl, str, sc); end
      $display("random game %0d: level %0d score %0d strikes %0d win %0d", g, lvl, sc, str, won);
    end
  endtask

  initial begin
    m_if.iSpace = 1'b0; m_if.iDoneLoad = 1'b0; m_if.iChoseCorrectNum = 1'b0; m_if.iChoseWrongNum = 1'b0;
    w_if.iSpace = 1'b0; w_if.iDoneLoad = 1'b0; w_if.iChoseCorrectNum = 1'b0; w_if.iChoseWrongNum = 1'b0;
    test_reset();
    test_level_clear();
    test_strikes();
    test_end_ignores_and_restart();
    test_both_pulses();
    test_reset_mid();
    test_win();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
